// File: rtl/prio_mux_reg.sv
// prio_mux_reg: fixed-priority N:1 mux into a one-deep output register.
// Define PRIO_MUX_AGING_EN to add per-channel wait counters that promote starved channels.
module prio_mux_reg #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int AGE_LIMIT = 7
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N-1:0]                       in_valid,
    input  logic [N*W-1:0]                     in_data,
    output logic [N-1:0]                       in_ready,
    output logic                               out_valid,
    output logic [W-1:0]                       out_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_chan,
    input  logic                               out_ready,
    output logic                               out_aged
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic          r_valid;
    logic [W-1:0]  r_data;
    logic [CW-1:0] r_chan;
    logic [N-1:0]  w_cand;
    logic [CW-1:0] w_idx;
    logic          w_any;
    logic          w_load;
    logic          w_fire;

    // Walk from the top down so the lowest-index candidate is the last write and wins.
    always_comb begin
        w_idx = '0;
        w_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_idx = CW'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_load    = !r_valid || out_ready;
    assign w_fire    = w_any && w_load && !rst;
    assign in_ready  = w_fire ? (N'(1) << w_idx) : '0;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_chan  = r_chan;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data <= in_data[w_idx*W +: W];
                r_chan <= w_idx;
            end
        end
    end

`ifdef PRIO_MUX_AGING_EN
    localparam logic [7:0] AL = 8'(AGE_LIMIT);

    logic [7:0]   r_age [N];
    logic [N-1:0] w_aged;
    logic         r_aged;

    // A counter can still read AL the cycle its requester drops, so qualify with in_valid.
    always_comb begin
        w_aged = '0;
        for (int i = 0; i < N; i++) w_aged[i] = in_valid[i] && (r_age[i] == AL);
    end

    assign w_cand   = (|w_aged) ? w_aged : in_valid;
    assign out_aged = r_aged;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst || !in_valid[i] || in_ready[i])
                r_age[i] <= '0;
            else if (r_age[i] != AL)
                r_age[i] <= r_age[i] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_aged <= 1'b0;
        else if (w_fire)
            r_aged <= |w_aged;
    end
`else
    assign w_cand   = in_valid;
    assign out_aged = 1'b0 && (AGE_LIMIT > 0);
`endif

endmodule
